// File: rtl/wdg_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wdg_mon_pkg
// Purpose  : Shared constants and types for the watchdog reset monitor.
//            Covers the register offsets, the unlock key, the STATUS bit map
//            and the strike FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package wdg_mon_pkg;

  // Register byte offsets relative to BASE_ADDR
  localparam logic [31:0] c_status_ofs = 32'h0;
  localparam logic [31:0] c_ctrl_ofs   = 32'h4;

  // A CTRL write of exactly this word releases a lockout
  localparam logic [31:0] c_unlock_key = 32'h5A5A_0001;

  // STATUS bit positions
  localparam int c_total_lsb   = 0;
  localparam int c_strikes_lsb = 8;
  localparam int c_locked_bit  = 16;
  localparam int c_sticky_bit  = 17;
  localparam int c_irq_en_bit  = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LOCKED = 2'd2
  } wdg_state_e;

  // Assemble the STATUS word; every unnamed bit stays 0
  function automatic logic [31:0] pack_status(
    input logic [7:0] total,
    input logic [3:0] strikes,
    input logic       locked,
    input logic       sticky,
    input logic       irq_en
  );
    logic [31:0] v;
    v = 32'h0;
    v[c_total_lsb   +: 8] = total;
    v[c_strikes_lsb +: 4] = strikes;
    v[c_locked_bit]       = locked;
    v[c_sticky_bit]       = sticky;
    v[c_irq_en_bit]       = irq_en;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wdg_rst_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : wdg_rst_monitor_if
// Purpose  : Wishbone classic slave bundle for the watchdog reset monitor.
//            Signal names are taken from the slave's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface wdg_rst_monitor_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic                     i_wb_cyc;
  logic                     i_wb_stb;
  logic                     i_wb_we;
  logic [WB_ADDR_WIDTH-1:0] i_wb_adr;
  logic [WB_DATA_WIDTH-1:0] i_wb_dat;
  logic [3:0]               i_wb_sel;
  logic                     o_wb_ack;
  logic                     o_wb_stall;
  logic [WB_DATA_WIDTH-1:0] o_wb_dat;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
    input  o_wb_ack, o_wb_stall, o_wb_dat
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel,
    output o_wb_ack, o_wb_stall, o_wb_dat
  );
endinterface
`default_nettype wire

// File: rtl/wdg_mon_wb_regs.sv
`default_nettype none
// ============================================================================
// Module   : wdg_mon_wb_regs
// Purpose  : Wishbone decode, single-cycle ack and STATUS readback for the
//            watchdog reset monitor. CTRL writes are turned into one-cycle
//            command strobes for the top level.
// Revision : 1.0 - initial release
// ============================================================================
module wdg_mon_wb_regs
  import wdg_mon_pkg::*;
#(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = WB_ADDR_WIDTH'(32'h8)
) (
  input  logic               clk,
  input  logic               res_n,
  wdg_rst_monitor_if.slave   wb,
  input  logic [31:0]        i_status,
  output logic               o_unlock,
  output logic               o_clr,
  output logic               o_irq_en_we,
  output logic               o_irq_en_dat
);

  localparam logic [WB_ADDR_WIDTH-1:0] c_status_adr = BASE_ADDR + WB_ADDR_WIDTH'(c_status_ofs);
  localparam logic [WB_ADDR_WIDTH-1:0] c_ctrl_adr   = BASE_ADDR + WB_ADDR_WIDTH'(c_ctrl_ofs);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_access;
  logic        w_wr;
  logic        w_cfg;
  logic [31:0] w_wdat;

  // A new access is any strobe not already being acknowledged
  assign w_access = wb.i_wb_cyc & wb.i_wb_stb & ~r_ack;
  assign w_wdat   = 32'(wb.i_wb_dat);

  // Only full-word CTRL writes have side effects
  assign w_wr  = w_access & wb.i_wb_we & (wb.i_wb_sel == 4'b1111) & (wb.i_wb_adr == c_ctrl_adr);
  assign w_cfg = w_wr & (w_wdat[31:16] == 16'h0);

  assign o_unlock     = w_wr & (w_wdat == c_unlock_key);
  assign o_clr        = w_cfg & w_wdat[0];
  assign o_irq_en_we  = w_cfg;
  assign o_irq_en_dat = w_wdat[2];

  assign wb.o_wb_ack   = r_ack;
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_dat   = WB_DATA_WIDTH'(r_dat);

  // Ack every access one cycle later; read data is non-zero only with ack
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_access;
      r_dat <= (w_access && !wb.i_wb_we && (wb.i_wb_adr == c_status_adr)) ? i_status : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wdg_rst_monitor.sv
`default_nettype none
// ============================================================================
// Module   : wdg_rst_monitor
// Purpose  : Counts watchdog timeouts, locks the core in hold after
//            MAX_STRIKES timeouts inside one quiet window, and exposes
//            STATUS/CTRL over Wishbone. Reset only by system reset so that
//            counts survive core resets.
// Options  : WDG_MON_IRQ_EN - enables the IRQ_EN bit and the o_irq pulse.
// Revision : 1.0 - initial release
// ============================================================================
module wdg_rst_monitor
  import wdg_mon_pkg::*;
#(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = WB_ADDR_WIDTH'(32'h8),
  parameter int                       MAX_STRIKES   = 3,
  parameter int                       WINDOW_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             wdg_to,
  wdg_rst_monitor_if.slave wb,
  output logic             o_hold_n,
  output logic             o_irq
);

  localparam int                c_win_w    = $clog2(WINDOW_CYCLES);
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_CYCLES - 1);
  localparam logic [3:0]        c_max      = 4'(MAX_STRIKES);

  wdg_state_e         r_state;
  wdg_state_e         w_state_nxt;
  logic [3:0]         r_strikes;
  logic [3:0]         w_strikes_nxt;
  logic [c_win_w-1:0] r_win;
  logic [c_win_w-1:0] w_win_nxt;
  logic [7:0]         r_total;
  logic               r_sticky;
  logic               r_wdg_to_q;
  logic               r_hold_n;
  logic               w_evt;
  logic               w_irq_en;
  logic               w_unlock;
  logic               w_clr;
  logic               w_irq_en_we;
  logic               w_irq_en_dat;
  logic [31:0]        w_status;

  // Rising edge of the timeout level; a held level counts once
  assign w_evt    = wdg_to & ~r_wdg_to_q;
  assign o_hold_n = r_hold_n;
  assign w_status = pack_status(r_total, r_strikes, (r_state == ST_LOCKED), r_sticky, w_irq_en);

  wdg_mon_wb_regs #(
    .WB_ADDR_WIDTH (WB_ADDR_WIDTH),
    .WB_DATA_WIDTH (WB_DATA_WIDTH),
    .BASE_ADDR     (BASE_ADDR)
  ) u_regs (
    .clk          (clk),
    .res_n        (res_n),
    .wb           (wb),
    .i_status     (w_status),
    .o_unlock     (w_unlock),
    .o_clr        (w_clr),
    .o_irq_en_we  (w_irq_en_we),
    .o_irq_en_dat (w_irq_en_dat)
  );

  // Strike FSM next-state: events add strikes, a quiet window clears them
  always_comb begin
    w_state_nxt   = r_state;
    w_strikes_nxt = r_strikes;
    w_win_nxt     = r_win;
    case (r_state)
      ST_IDLE: begin
        if (w_evt) begin
          w_strikes_nxt = 4'd1;
          w_win_nxt     = '0;
          w_state_nxt   = (MAX_STRIKES == 1) ? ST_LOCKED : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_evt) begin
          w_strikes_nxt = r_strikes + 4'd1;
          w_win_nxt     = '0;
          if ((r_strikes + 4'd1) == c_max) w_state_nxt = ST_LOCKED;
        end else if (r_win == c_win_last) begin
          w_strikes_nxt = 4'd0;
          w_win_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_win_nxt = r_win + c_win_w'(1);
        end
      end
      ST_LOCKED: begin
        if (w_unlock) begin
          w_strikes_nxt = 4'd0;
          w_win_nxt     = '0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: begin
        w_strikes_nxt = 4'd0;
        w_win_nxt     = '0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State, strike counters and the registered hold output
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state   <= ST_IDLE;
      r_strikes <= 4'd0;
      r_win     <= '0;
      r_hold_n  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_strikes <= w_strikes_nxt;
      r_win     <= w_win_nxt;
      r_hold_n  <= (w_state_nxt != ST_LOCKED);
    end
  end

  // Event edge detect, saturating total and sticky flag (clear before count)
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_wdg_to_q <= 1'b0;
      r_total    <= 8'd0;
      r_sticky   <= 1'b0;
    end else begin
      r_wdg_to_q <= wdg_to;
      if (w_clr) begin
        r_total  <= w_evt ? 8'd1 : 8'd0;
        r_sticky <= w_evt;
      end else if (w_evt) begin
        r_sticky <= 1'b1;
        if (r_total != 8'hFF) r_total <= r_total + 8'd1;
      end
    end
  end

`ifdef WDG_MON_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Interrupt enable register and one-cycle pulse after each event
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= w_evt & r_irq_en;
      if (w_irq_en_we) r_irq_en <= w_irq_en_dat;
    end
  end

  assign w_irq_en = r_irq_en;
  assign o_irq    = r_irq;
`else
  logic w_unused_irq;
  assign w_unused_irq = w_irq_en_we ^ w_irq_en_dat;
  assign w_irq_en     = 1'b0;
  assign o_irq        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wdg_rst_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdg_rst_monitor
// Purpose  : Self-checking bench for wdg_rst_monitor: directed scenarios with
//            literal expectations plus randomized traffic against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdg_rst_monitor;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam logic [31:0] BASE = 32'h8;
  localparam logic [31:0] CTRL = 32'hC;
  localparam logic [31:0] KEY  = 32'h5A5A_0001;
  localparam int          MAXS = 3;
  localparam int          WIN  = 1024;
`ifdef WDG_MON_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk    = 1'b0;
  logic res_n  = 1'b0;
  logic wdg_to = 1'b0;
  logic hold_n;
  logic irq;

  wdg_rst_monitor_if #(.WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) wb_if ();

  wdg_rst_monitor #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .BASE_ADDR     (BASE),
    .MAX_STRIKES   (MAXS),
    .WINDOW_CYCLES (WIN)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .wdg_to   (wdg_to),
    .wb       (wb_if),
    .o_hold_n (hold_n),
    .o_irq    (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 1'b0;
  bit          m_to_q, m_locked, m_sticky, m_irq_en, m_ack, m_irq, m_hold;
  int          m_total, m_strikes, m_quiet;
  logic [31:0] m_dat;

  always @(posedge clk) begin : p_model
    int t, s, q;
    bit lk, st, ie, ev, acc, wr, unl, cfg;
    logic [31:0] d, rd;
    if (!res_n) begin
      m_to_q <= 1'b0; m_total <= 0; m_strikes <= 0; m_quiet <= 0;
      m_locked <= 1'b0; m_sticky <= 1'b0; m_irq_en <= 1'b0;
      m_ack <= 1'b0; m_dat <= 32'h0; m_irq <= 1'b0; m_hold <= 1'b1; m_ok <= 1'b1;
    end else begin
      t = m_total; s = m_strikes; q = m_quiet; lk = m_locked; st = m_sticky; ie = m_irq_en;
      ev  = wdg_to && !m_to_q;
      acc = wb_if.i_wb_cyc && wb_if.i_wb_stb && !m_ack;
      rd  = {13'd0, ie, st, lk, 4'd0, 4'(s), 8'(t)};
      d   = wb_if.i_wb_dat;
      wr  = acc && wb_if.i_wb_we && (wb_if.i_wb_sel == 4'hF) && (wb_if.i_wb_adr == CTRL);
      unl = wr && (d == KEY);
      cfg = wr && (d[31:16] == 16'h0);
      if (cfg && d[0]) begin t = 0; st = 1'b0; end
      if (ev) begin t = (t < 255) ? t + 1 : 255; st = 1'b1; end
      if (lk) begin
        if (unl) begin lk = 1'b0; s = 0; q = 0; end
      end else if (ev) begin
        s = s + 1; q = 0;
        if (s == MAXS) lk = 1'b1;
      end else if (s > 0) begin
        q = q + 1;
        if (q == WIN) begin s = 0; q = 0; end
      end
      m_irq <= IRQ_ON && ev && m_irq_en;
      if (cfg && IRQ_ON) ie = d[2];
      m_to_q <= wdg_to; m_total <= t; m_strikes <= s; m_quiet <= q;
      m_locked <= lk; m_sticky <= st; m_irq_en <= ie;
      m_ack <= acc;
      m_dat <= (acc && !wb_if.i_wb_we && (wb_if.i_wb_adr == BASE)) ? rd : 32'h0;
      m_hold <= !lk;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("ack",    32'(wb_if.o_wb_ack),   32'(m_ack));
      chk("stall",  32'(wb_if.o_wb_stall), 32'h0);
      chk("rdata",  wb_if.o_wb_dat,        m_dat);
      chk("hold_n", 32'(hold_n),           32'(m_hold));
      chk("irq",    32'(irq),              32'(m_irq));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic bus_idle();
    wb_if.i_wb_cyc = 1'b0; wb_if.i_wb_stb = 1'b0; wb_if.i_wb_we = 1'b0;
    wb_if.i_wb_adr = '0;   wb_if.i_wb_dat = '0;   wb_if.i_wb_sel = 4'h0;
  endtask

  task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input bit evt, output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb_if.i_wb_cyc = 1'b1; wb_if.i_wb_stb = 1'b1; wb_if.i_wb_we = we;
    wb_if.i_wb_adr = adr;  wb_if.i_wb_dat = dat;  wb_if.i_wb_sel = 4'hF;
    if (evt) wdg_to = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_if.o_wb_ack && n < 8);
    chk("ack_latency", n, 1);
    rdat = wb_if.o_wb_dat;
    bus_idle();
    wdg_to = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
    wb_xfer(1'b0, adr, 32'h0, 1'b0, rdat);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, dat, 1'b0, dummy);
  endtask

  task automatic pulse();
    @(negedge clk); wdg_to = 1'b1;
    @(negedge clk); wdg_to = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int          n;
    bus_idle();
    repeat (3) @(negedge clk);
    chk("rst_hold_n", 32'(hold_n), 32'h1);
    chk("rst_irq",    32'(irq),    32'h0);
    chk("rst_ack",    32'(wb_if.o_wb_ack), 32'h0);
    res_n = 1'b1;

    wb_read(BASE, rd);
    chk("status_after_reset", rd, 32'h0);

    // two strikes, then a quiet window clears them
    pulse(); repeat (100) @(negedge clk); pulse();
    wb_read(BASE, rd);
    chk("two_strikes", rd, 32'h0002_0202);
    repeat (1030) @(negedge clk);
    wb_read(BASE, rd);
    chk("window_expired", rd, 32'h0002_0002);

    // clear, then lock with three strikes and unlock
    wb_write(CTRL, 32'h1);
    wb_read(BASE, rd);
    chk("cleared", rd, 32'h0);
    pulse(); repeat (10) @(negedge clk);
    pulse(); repeat (10) @(negedge clk);
    pulse();
    chk("locked_hold_n", 32'(hold_n), 32'h0);
    wb_read(BASE, rd);
    chk("locked_status", rd, 32'h0003_0303);
    wb_write(CTRL, KEY);
    chk("unlocked_hold_n", 32'(hold_n), 32'h1);
    wb_read(BASE, rd);
    chk("unlocked_status", rd, 32'h0002_0003);

    // a held level counts once
    wb_write(CTRL, 32'h1);
    @(negedge clk); wdg_to = 1'b1;
    repeat (50) @(negedge clk);
    wdg_to = 1'b0;
    wb_read(BASE, rd);
    chk("held_level", rd, 32'h0002_0101);

    // saturation at 255
    for (int i = 0; i < 300; i++) pulse();
    wb_read(BASE, rd);
    chk("total_saturated", rd & 32'h0001_00FF, 32'h0001_00FF);
    wb_write(CTRL, KEY);

    // clear coincident with an event: clear first, then count
    wb_xfer(1'b1, CTRL, 32'h1, 1'b1, rd);
    wb_read(BASE, rd);
    chk("clear_vs_event", rd & 32'h0002_00FF, 32'h0002_0001);

    // interrupt pulse width
    wb_write(CTRL, 32'h4);
    pulse();
    n = irq ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (irq) n++;
    end
    chk("irq_pulse_cycles", n, IRQ_ON ? 1 : 0);
    wb_read(BASE, rd);
    chk("irq_en_bit", 32'(rd[18]), 32'(IRQ_ON));

    // randomized traffic, including occasional resets and a long quiet run
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      res_n = ($urandom_range(0, 599) != 0);
      if (i >= 2000 && i < 3300) wdg_to = 1'b0;
      else if ($urandom_range(0, 9) == 0) wdg_to = ~wdg_to;
      wb_if.i_wb_cyc = ($urandom_range(0, 3) != 0);
      wb_if.i_wb_stb = ($urandom_range(0, 2) != 0);
      wb_if.i_wb_we  = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 3))
        0: wb_if.i_wb_adr = BASE;
        1: wb_if.i_wb_adr = CTRL;
        2: wb_if.i_wb_adr = BASE + 32'h8;
        default: wb_if.i_wb_adr = 32'h0;
      endcase
      wb_if.i_wb_sel = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: wb_if.i_wb_dat = KEY;
        1: wb_if.i_wb_dat = 32'h1;
        2: wb_if.i_wb_dat = 32'h4;
        3: wb_if.i_wb_dat = 32'h5;
        4: wb_if.i_wb_dat = 32'h0;
        default: wb_if.i_wb_dat = $urandom;
      endcase
    end
    @(negedge clk);
    res_n = 1'b1;
    bus_idle();
    wdg_to = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
